operand_fetch_stage: RTL and testbench

- Pipeline stage between instruction decode and execute.
- Drives the two combinational read ports of the register file and bypasses same-cycle writeback data.
- Tracks in-flight destination registers in a scoreboard and stalls issue on RAW/WAW hazards.
- Presents registered operands to execute over a valid/ready handshake.

---
 rtl/operand_fetch_stage.sv | 153 +++++++++++++++
 tb/tb_operand_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_stage
// Purpose  : Pipeline stage between decode and execute. Drives the register
//            file read addresses, bypasses same-cycle writeback data, tracks
//            in-flight destinations in a scoreboard, stalls on RAW/WAW
//            hazards and hands registered operands to execute over a
//            valid/ready handshake.
// Ports    : clk, rst_n (async, active-low)
//            in_*        decode-side instruction + handshake
//            rf_rd_*     register file read ports (addresses combinational)
//            wb_*        writeback bus (also the register file write port)
//            out_*       execute-side operands + handshake
//            busy_vec    scoreboard state (bit 0 always 0)
//            stall_cnt   saturating count of hazard-stalled request cycles
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DEPTH-1:0]        in_rs1,
  input  logic [DEPTH-1:0]        in_rs2,
  input  logic [DEPTH-1:0]        in_rd,
  input  logic                    in_rd_we,
  output logic [DEPTH-1:0]        rf_rd_addr1,
  output logic [DEPTH-1:0]        rf_rd_addr2,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data1,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data2,
  input  logic                    wb_valid,
  input  logic [DEPTH-1:0]        wb_addr,
  input  logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_op1,
  output logic [DATA_WIDTH-1:0]   out_op2,
  output logic [DEPTH-1:0]        out_rd,
  output logic                    out_rd_we,
  output logic [(2**DEPTH)-1:0]   busy_vec,
  output logic [CNT_WIDTH-1:0]    stall_cnt
);

  localparam int NREG = 2 ** DEPTH;

  // Registered state
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_op1_q,   out_op1_d;
  logic [DATA_WIDTH-1:0] out_op2_q,   out_op2_d;
  logic [DEPTH-1:0]      out_rd_q,    out_rd_d;
  logic                  out_rd_we_q, out_rd_we_d;
  logic [NREG-1:0]       busy_q,      busy_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  // Combinational helpers
  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] busy_eff;
  logic            rd_nonzero;
  logic            raw1, raw2, waw, hazard;
  logic            accept;

  // One-hot writeback decode; register 0 never matches so writes to it are
  // invisible to both bypass and scoreboard.
  generate
    for (genvar r = 0; r < NREG; r++) begin : g_wb_hit
      if (r == 0) begin : g_zero
        assign wb_hit[r] = 1'b0;
      end else begin : g_reg
        assign wb_hit[r] = wb_valid && (wb_addr == DEPTH'(r));
      end
    end
  endgenerate

  // A register being written back this cycle is already resolved: its value
  // is available on the bypass path, so it does not block issue.
  assign busy_eff   = busy_q & ~wb_hit;
  assign rd_nonzero = (in_rd != '0);

  assign raw1   = busy_eff[in_rs1];
  assign raw2   = busy_eff[in_rs2];
  assign waw    = in_rd_we && rd_nonzero && busy_eff[in_rd];
  assign hazard = raw1 || raw2 || waw;

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  assign rf_rd_addr1 = in_rs1;
  assign rf_rd_addr2 = in_rs2;

  always_comb begin
    out_valid_d = out_valid_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    busy_d      = busy_q & ~wb_hit;
    stall_cnt_d = stall_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_op1_d   = wb_hit[in_rs1] ? wb_data : rf_rd_data1;
      out_op2_d   = wb_hit[in_rs2] ? wb_data : rf_rd_data2;
      out_rd_d    = in_rd;
      out_rd_we_d = in_rd_we && rd_nonzero;
      // Applied after the clear so a same-cycle set on the same register wins.
      if (in_rd_we && rd_nonzero) begin
        busy_d[in_rd] = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d[0] = 1'b0;

    if (in_valid && hazard && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;
  assign busy_vec  = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch_stage
// Purpose  : Directed self-checking bench for operand_fetch_stage with a
//            small behavioural register file attached to the read/write ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;

  localparam int DW = 8;
  localparam int DP = 2;
  localparam int CW = 4;   // narrow counter so saturation is reachable

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DP-1:0] in_rs1, in_rs2, in_rd;
  logic          in_rd_we;
  logic [DP-1:0] rf_rd_addr1, rf_rd_addr2;
  logic [DW-1:0] rf_rd_data1, rf_rd_data2;
  logic          wb_valid;
  logic [DP-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_op1, out_op2;
  logic [DP-1:0] out_rd;
  logic          out_rd_we;
  logic [3:0]    busy_vec;
  logic [CW-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural register file: r0 reads 0, writes to r0 ignored.
  logic [DW-1:0] rf [4];
  logic          rf_load;

  always @(posedge clk) begin
    if (rf_load) begin
      rf[0] <= 8'h00;
      rf[1] <= 8'h11;
      rf[2] <= 8'h22;
      rf[3] <= 8'h33;
    end else if (wb_valid && wb_addr != 2'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  assign rf_rd_data1 = (rf_rd_addr1 == 2'd0) ? 8'h00 : rf[rf_rd_addr1];
  assign rf_rd_data2 = (rf_rd_addr2 == 2'd0) ? 8'h00 : rf[rf_rd_addr2];

  operand_fetch_stage #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_rd_we   (in_rd_we),
    .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1),
    .rf_rd_data2(rf_rd_data2),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_rd     (out_rd),
    .out_rd_we  (out_rd_we),
    .busy_vec   (busy_vec),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [1:0] rd, input logic we);
    in_valid = v;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_rd_we = we;
  endtask

  task automatic drive_wb(input logic v, input logic [1:0] a, input logic [7:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    rf_load   = 1'b1;
    out_ready = 1'b1;
    drive_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    drive_wb(1'b0, 2'd0, 8'h00);
    tick();
    tick();
    rst_n   = 1'b1;
    rf_load = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ops",       {out_op1, out_op2}, 32'h0000);
    check("rst_rd",        {out_rd, out_rd_we}, 32'd0);
    check("rst_busy",      32'(busy_vec), 32'h0);
    check("rst_stall",     32'(stall_cnt), 32'd0);

    // Independent issue: rs1=1, rs2=2, rd=3
    drive_in(1'b1, 2'd1, 2'd2, 2'd3, 1'b1);
    #1;
    check("iss_in_ready", 32'(in_ready), 32'd1);
    check("iss_rf_addr",  {rf_rd_addr1, rf_rd_addr2}, 32'b0110);
    tick();
    check("iss_valid", 32'(out_valid), 32'd1);
    check("iss_op1",   32'(out_op1), 32'h11);
    check("iss_op2",   32'(out_op2), 32'h22);
    check("iss_rd",    {out_rd, out_rd_we}, 32'b111);
    check("iss_busy",  32'(busy_vec), 32'b1000);

    // RAW stall on r3
    drive_in(1'b1, 2'd3, 2'd0, 2'd1, 1'b1);
    #1;
    check("raw_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("raw_valid_drop", 32'(out_valid), 32'd0);
    check("raw_stall1",     32'(stall_cnt), 32'd1);
    tick();
    check("raw_stall2",     32'(stall_cnt), 32'd2);
    // Writeback of r3 in the same cycle resolves the hazard via bypass
    drive_wb(1'b1, 2'd3, 8'h5A);
    #1;
    check("raw_wb_ready", 32'(in_ready), 32'd1);
    tick();
    check("raw_op1_bypass", 32'(out_op1), 32'h5A);
    check("raw_op2",        32'(out_op2), 32'h00);
    check("raw_rd",         {out_rd, out_rd_we}, 32'b011);
    check("raw_busy",       32'(busy_vec), 32'b0010);
    check("raw_stall_hold", 32'(stall_cnt), 32'd2);

    // Register 0 source/dest, with a writeback to r0 that must be ignored
    drive_in(1'b1, 2'd0, 2'd0, 2'd0, 1'b1);
    drive_wb(1'b1, 2'd0, 8'hFF);
    #1;
    check("r0_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("r0_ops",  {out_op1, out_op2}, 32'h0000);
    check("r0_rd",   {out_rd, out_rd_we}, 32'b000);
    check("r0_busy", 32'(busy_vec), 32'b0010);
    drive_wb(1'b0, 2'd0, 8'h00);

    // Backpressure: out_* held, no accept
    out_ready = 1'b0;
    drive_in(1'b1, 2'd2, 2'd3, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_hold", {out_valid, out_op1, out_op2, out_rd, out_rd_we}, {1'b1, 8'h00, 8'h00, 2'd0, 1'b0});
    end
    check("bp_busy",  32'(busy_vec), 32'b0010);
    check("bp_stall", 32'(stall_cnt), 32'd2);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_ops",  {out_op1, out_op2}, 32'h225A);
    check("bp_rd",   {out_rd, out_rd_we}, 32'b101);
    check("bp_busy2", 32'(busy_vec), 32'b0110);

    // Set/clear collision on r2: WAW resolved by writeback, set wins
    drive_in(1'b1, 2'd0, 2'd0, 2'd2, 1'b1);
    drive_wb(1'b1, 2'd2, 8'h77);
    #1;
    check("col_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("col_busy",  32'(busy_vec), 32'b0110);
    check("col_rd",    {out_valid, out_rd, out_rd_we}, 32'b1101);
    drive_wb(1'b0, 2'd0, 8'h00);

    // Saturation: RAW on busy r1 while execute is stalled; count 2 -> 15
    out_ready = 1'b0;
    drive_in(1'b1, 2'd1, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 13; i++) tick();
    check("sat_reach", 32'(stall_cnt), 32'd15);
    for (int i = 0; i < 3; i++) tick();
    check("sat_hold",  32'(stall_cnt), 32'd15);
    check("sat_valid_held", {out_valid, 4'(busy_vec)}, {1'b1, 4'b0110});

    // Asynchronous reset mid-stream
    drive_in(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data",  {out_op1, out_op2, out_rd, out_rd_we}, 32'd0);
    check("arst_busy",  32'(busy_vec), 32'd0);
    check("arst_stall", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_stall", 32'(stall_cnt), 32'd0);
    check("post_rst_busy",  32'(busy_vec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
